spislave_core: RTL and testbench

SPISLAVE_CORE -- requirements
Module: spislave_core

---
 rtl/spislave_core.sv | 198 +++++++++++++++++++
 tb/tb_spislave_core.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spislave_core.sv
// SPI slave core: oversampled SCK/SDI/CS, all four SPI modes, one-word transmit buffer.
// Optional feature macro SPISLAVE_OVERRUN_EN adds the RxAck input and a sticky Overrun flag.
`timescale 1ns/1ps
module spislave_core #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = '1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [1:0]            Mode,
    input  logic                  SCK,
    input  logic                  SDI,
    input  logic                  CS,
    output logic                  SDO,
    input  logic [DATA_WIDTH-1:0] TxData,
    input  logic                  TxLoad,
    output logic                  TxReady,
    output logic [DATA_WIDTH-1:0] RxData,
    output logic                  RxValid,
`ifdef SPISLAVE_OVERRUN_EN
    input  logic                  RxAck,
`endif
    output logic                  Busy
`ifdef SPISLAVE_OVERRUN_EN
    ,
    output logic                  Overrun
`endif
);

    localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_WAIT_CS = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q, cs_prev_d;

    logic [1:0]            mode_q, mode_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-2:0] rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic                  tx_full_q, tx_full_d;
`ifdef SPISLAVE_OVERRUN_EN
    logic                  unacked_q, unacked_d;
    logic                  overrun_q, overrun_d;
`endif

    logic                  sck_s, sdi_s, cs_s;
    logic                  cs_fall, start_frame, in_shift;
    logic                  lead, trail, sample, advance;
    logic                  last_bit, word_done, word_start;
    logic                  consume, accept;
    logic [DATA_WIDTH-1:0] rx_word;

    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], SCK};
        sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], SDI};
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], CS};
        sck_s      = sck_sync_q[SYNC_STAGES-1];
        sdi_s      = sdi_sync_q[SYNC_STAGES-1];
        cs_s       = cs_sync_q[SYNC_STAGES-1];
        sck_prev_d = sck_s;
        cs_prev_d  = cs_s;
    end

    // Edge decode: leading moves SCK away from CPOL, trailing returns to it.
    // A word starts on the first advance edge with the counter at zero; in CPHA=0
    // that is the trailing edge after the last sample, giving back-to-back words.
    always_comb begin
        cs_fall     = cs_prev_q & ~cs_s;
        start_frame = (state_q == ST_IDLE) && cs_fall;
        in_shift    = (state_q == ST_SHIFT) && !cs_s;
        lead        = in_shift && (sck_s != sck_prev_q) && (sck_s != mode_q[1]);
        trail       = in_shift && (sck_s != sck_prev_q) && (sck_s == mode_q[1]);
        sample      = mode_q[0] ? trail : lead;
        advance     = mode_q[0] ? lead : trail;
        last_bit    = (cnt_q == LAST_BIT);
        word_done   = sample && last_bit;
        word_start  = (start_frame && !Mode[0]) || (advance && (cnt_q == '0));
        consume     = word_start && tx_full_q;
        accept      = TxLoad && (!tx_full_q || consume);
        rx_word     = {rx_sr_q, sdi_s};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cs_fall) state_d = ST_SHIFT;
            ST_SHIFT:   if (cs_s)    state_d = ST_IDLE;
            ST_WAIT_CS: if (cs_s)    state_d = ST_IDLE;
            default:                 state_d = ST_WAIT_CS;
        endcase
    end

    always_comb begin
        mode_d = start_frame ? Mode : mode_q;

        cnt_d = cnt_q;
        if (start_frame || !in_shift) begin
            cnt_d = '0;
        end else if (sample) begin
            cnt_d = last_bit ? '0 : cnt_q + CNT_W'(1);
        end

        rx_sr_d    = sample ? rx_word[DATA_WIDTH-2:0] : rx_sr_q;
        rx_data_d  = word_done ? rx_word : rx_data_q;
        rx_valid_d = word_done;

        tx_sr_d = tx_sr_q;
        if (word_start) begin
            tx_sr_d = tx_full_q ? tx_buf_q : DEFAULT_TX;
        end else if (advance) begin
            tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
        end

        tx_buf_d  = accept ? TxData : tx_buf_q;
        tx_full_d = accept || (tx_full_q && !consume);

`ifdef SPISLAVE_OVERRUN_EN
        unacked_d = word_done || (unacked_q && !RxAck);
        overrun_d = overrun_q || (word_done && unacked_q && !RxAck);
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_WAIT_CS;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            cs_sync_q  <= '0;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b0;
            mode_q     <= '0;
            cnt_q      <= '0;
            tx_sr_q    <= DEFAULT_TX;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
`ifdef SPISLAVE_OVERRUN_EN
            unacked_q  <= 1'b0;
            overrun_q  <= 1'b0;
`endif
        end else begin
            sck_sync_q <= sck_sync_d;
            sdi_sync_q <= sdi_sync_d;
            cs_sync_q  <= cs_sync_d;
            sck_prev_q <= sck_prev_d;
            cs_prev_q  <= cs_prev_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
`ifdef SPISLAVE_OVERRUN_EN
            unacked_q  <= unacked_d;
            overrun_q  <= overrun_d;
`endif
        end
    end

    always_comb begin
        Busy    = (state_q == ST_SHIFT);
        TxReady = !tx_full_q;
        RxData  = rx_data_q;
        RxValid = rx_valid_q;
`ifdef SPISLAVE_OVERRUN_EN
        Overrun = overrun_q;
`endif
    end

    assign SDO = in_shift ? tx_sr_q[DATA_WIDTH-1] : 1'bz;

endmodule

// File: tb/tb_spislave_core.sv
// Randomized bench for spislave_core: SPI master tasks drive frames, a word-level
// model predicts SDO words and received words; a per-cycle process checks the DUT.
`timescale 1ns/1ps
module tb_spislave_core;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [1:0] Mode;
    logic       SCK, SDI, CS;
    wire        SDO;
    logic [7:0] TxData;
    logic       TxLoad;
    logic       TxReady;
    logic [7:0] RxData;
    logic       RxValid;
    logic       Busy;
`ifdef SPISLAVE_OVERRUN_EN
    logic       RxAck;
    logic       Overrun;
    logic       ack_en = 1'b1;
`endif

    spislave_core #(.DATA_WIDTH(8), .SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
        .Clk(Clk), .Rst(Rst), .Mode(Mode), .SCK(SCK), .SDI(SDI), .CS(CS), .SDO(SDO),
        .TxData(TxData), .TxLoad(TxLoad), .TxReady(TxReady),
        .RxData(RxData), .RxValid(RxValid),
`ifdef SPISLAVE_OVERRUN_EN
        .RxAck(RxAck),
`endif
        .Busy(Busy)
`ifdef SPISLAVE_OVERRUN_EN
        , .Overrun(Overrun)
`endif
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    logic sdo_z;
    assign sdo_z = (SDO === 1'bz);

    logic [7:0] tx_pending[$];
    logic [7:0] exp_rx[$];
    logic [7:0] tx_w[4];
    logic [7:0] mosi_w[4];
    logic [7:0] cap[4];
    logic [7:0] last_rx = 8'h00;
    logic       in_frame = 1'b0;
    logic       rxv_prev = 1'b0;
    int         cs_hi_cnt = 0;
    int         rx_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the word-level model.
    always @(negedge Clk) begin
        cs_hi_cnt = CS ? cs_hi_cnt + 1 : 0;
        if (cs_hi_cnt > 6) begin
            check("idle_sdo_z", sdo_z, 1'b1);
            check("idle_busy", Busy, 1'b0);
        end
        if (in_frame) check("frame_busy", Busy, 1'b1);
        if (RxValid) begin
            rx_pulses++;
            if (rxv_prev) check("rxvalid_width", 1'b1, 1'b0);
            if (exp_rx.size() == 0) check("rxvalid_spurious", 1'b1, 1'b0);
            else check("rx_data", RxData, exp_rx.pop_front());
        end
        rxv_prev = RxValid;
    end

    // Transmit buffer feeder: loads queued words when TxReady is high, sometimes
    // follows with a junk strobe while TxReady is low, which must be ignored.
    initial begin
        TxLoad = 1'b0;
        TxData = 8'h00;
        forever begin
            @(negedge Clk);
            if (!Rst && TxReady && tx_pending.size() > 0) begin
                TxData = tx_pending.pop_front();
                TxLoad = 1'b1;
                @(negedge Clk);
                TxLoad = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    TxData = 8'($urandom);
                    TxLoad = 1'b1;
                    @(negedge Clk);
                    TxLoad = 1'b0;
                end
            end
        end
    end

`ifdef SPISLAVE_OVERRUN_EN
    initial begin
        RxAck = 1'b0;
        forever begin
            @(negedge Clk);
            RxAck = ack_en && RxValid;
        end
    end
`endif

    // One CS frame of nw words (or part_bits bits if nonzero); the first k tx_w words
    // are offered to the buffer, later words must come out as 0xFF.
    task automatic run_frame(input logic [1:0] mode, input int nw, input int k, input int part_bits);
        int  h, total, j, bi;
        logic cpol, cpha;
        h    = 10 * $urandom_range(6, 10);
        cpol = mode[1];
        cpha = mode[0];
        Mode = mode;
        SCK  = cpol;
        repeat (6) @(negedge Clk);
        for (int i = 0; i < k; i++) tx_pending.push_back(tx_w[i]);
        repeat (6) @(negedge Clk);
        total = (part_bits > 0) ? part_bits : nw * 8;
        SDI = mosi_w[0][7];
        CS  = 1'b0;
        #(h);
        in_frame = 1'b1;
        for (int b = 0; b < total; b++) begin
            j  = b / 8;
            bi = 7 - (b % 8);
            if ((b % 8) == 0 && part_bits == 0) exp_rx.push_back(mosi_w[j]);
            if (!cpha) begin
                cap[j][bi] = SDO;
                SCK = ~cpol;
                #(h);
                SCK = cpol;
                if (b + 1 < total) SDI = mosi_w[(b + 1) / 8][7 - ((b + 1) % 8)];
                #(h);
            end else begin
                SCK = ~cpol;
                SDI = mosi_w[j][bi];
                #(h);
                cap[j][bi] = SDO;
                SCK = cpol;
                #(h);
            end
        end
        in_frame = 1'b0;
        CS = 1'b1;
        repeat (10) @(negedge Clk);
        if (part_bits == 0) begin
            for (int i = 0; i < nw; i++)
                check("sdo_word", cap[i], (i < k) ? tx_w[i] : 8'hFF);
            last_rx = mosi_w[nw - 1];
        end else begin
            check("partial_rx_hold", RxData, last_rx);
        end
        check("rx_all_received", exp_rx.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

    initial begin
        int p0, nw, k;
        Rst = 1'b1; Mode = 2'b00; SCK = 1'b0; SDI = 1'b0; CS = 1'b1;
        repeat (4) @(negedge Clk);
        check("rst_rxdata", RxData, 8'h00);
        check("rst_rxvalid", RxValid, 1'b0);
        check("rst_txready", TxReady, 1'b1);
        check("rst_busy", Busy, 1'b0);
        check("rst_sdo_z", sdo_z, 1'b1);
`ifdef SPISLAVE_OVERRUN_EN
        check("rst_overrun", Overrun, 1'b0);
`endif
        Rst = 1'b0;
        repeat (6) @(negedge Clk);

        // Mode 0 single word.
        p0 = rx_pulses;
        tx_w[0] = 8'hAA; mosi_w[0] = 8'h3C;
        run_frame(2'd0, 1, 1, 0);
        check("m0_sdo_lit", cap[0], 8'hAA);
        check("m0_rx_lit", RxData, 8'h3C);
        check("m0_pulses", rx_pulses - p0, 1);

        // Modes 1..3.
        tx_w[0] = 8'h72; mosi_w[0] = 8'hA5;
        run_frame(2'd1, 1, 1, 0);
        check("m1_sdo_lit", cap[0], 8'h72);
        check("m1_rx_lit", RxData, 8'hA5);
        tx_w[0] = 8'hC3;
        run_frame(2'd2, 1, 1, 0);
        check("m2_sdo_lit", cap[0], 8'hC3);
        check("m2_rx_lit", RxData, 8'hA5);
        tx_w[0] = 8'h5D;
        run_frame(2'd3, 1, 1, 0);
        check("m3_sdo_lit", cap[0], 8'h5D);
        check("m3_rx_lit", RxData, 8'hA5);

        // Back-to-back two words in one frame.
        p0 = rx_pulses;
        tx_w[0] = 8'h12; tx_w[1] = 8'h34; mosi_w[0] = 8'h55; mosi_w[1] = 8'h0F;
        run_frame(2'd0, 2, 2, 0);
        check("b2b_sdo0_lit", cap[0], 8'h12);
        check("b2b_sdo1_lit", cap[1], 8'h34);
        check("b2b_rx_lit", RxData, 8'h0F);
        check("b2b_pulses", rx_pulses - p0, 2);

        // No load: default word.
        mosi_w[0] = 8'h81;
        run_frame(2'd0, 1, 0, 0);
        check("dflt_sdo_lit", cap[0], 8'hFF);

        // Partial frame, then a full one.
        p0 = rx_pulses;
        mosi_w[0] = 8'hF0;
        run_frame(2'd0, 1, 0, 5);
        check("partial_rx_lit", RxData, 8'h81);
        check("partial_no_pulse", rx_pulses - p0, 0);
        tx_w[0] = 8'h3A; mosi_w[0] = 8'h6E;
        run_frame(2'd0, 1, 1, 0);
        check("after_partial_rx_lit", RxData, 8'h6E);

        for (int f = 0; f < 24; f++) begin
            nw = $urandom_range(1, 3);
            k  = $urandom_range(0, nw);
            for (int i = 0; i < 4; i++) begin
                tx_w[i]   = 8'($urandom);
                mosi_w[i] = 8'($urandom);
            end
            if ((f % 6) == 5) run_frame(2'($urandom_range(0, 3)), 1, 0, $urandom_range(1, 7));
            else              run_frame(2'($urandom_range(0, 3)), nw, k, 0);
        end

        // Reset mid-frame with CS held low: slave must stay out of this frame.
        Mode = 2'b00; SCK = 1'b0; SDI = 1'b1;
        repeat (4) @(negedge Clk);
        CS = 1'b0;
        #80;
        for (int b = 0; b < 3; b++) begin SCK = 1'b1; #80; SCK = 1'b0; #80; end
        @(negedge Clk); Rst = 1'b1;
        @(negedge Clk); Rst = 1'b0;
        check("midrst_sdo_z", sdo_z, 1'b1);
        check("midrst_busy", Busy, 1'b0);
        last_rx = 8'h00;
        for (int b = 0; b < 8; b++) begin
            SDI = 1'($urandom);
            SCK = 1'b1; #80;
            check("waitcs_sdo_z", sdo_z, 1'b1);
            check("waitcs_busy", Busy, 1'b0);
            SCK = 1'b0; #80;
        end
        CS = 1'b1;
        repeat (10) @(negedge Clk);
        check("midrst_rxdata", RxData, 8'h00);
        check("midrst_txready", TxReady, 1'b1);
        tx_w[0] = 8'h9C; mosi_w[0] = 8'hE1;
        run_frame(2'd0, 1, 1, 0);
        check("post_rst_sdo_lit", cap[0], 8'h9C);
        check("post_rst_rx_lit", RxData, 8'hE1);

`ifdef SPISLAVE_OVERRUN_EN
        check("overrun_clear", Overrun, 1'b0);
        ack_en = 1'b0;
        mosi_w[0] = 8'h11; mosi_w[1] = 8'h22;
        run_frame(2'd0, 2, 0, 0);
        check("overrun_set", Overrun, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
